// File: rtl/wishbone_dmi_master_if.sv
// Bundle of the DMI request/response handshake and the Wishbone master bus used by
// wishbone_dmi_master.
//   cmd_*  : upstream DMI request (valid/ready, we, 32-bit addr, 64-bit wdata)
//   rsp_*  : upstream DMI response (valid/ready, 64-bit rdata, err = timeout)
//   addr_o/we_o/data_o/cyc_o/stb_o/data_i/ack_i : Wishbone master signals
// Signal suffixes are from the point of view of the master.
// The master modport is used by the DUT, the slave modport by whatever drives it.
interface wishbone_dmi_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [63:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] addr_o;
  logic        we_o;
  logic [63:0] data_o;
  logic        cyc_o;
  logic        stb_o;
  logic [63:0] data_i;
  logic        ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i, data_i, ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output addr_o, we_o, data_o, cyc_o, stb_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i, data_i, ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  addr_o, we_o, data_o, cyc_o, stb_o
  );
endinterface

// File: rtl/wishbone_dmi_master.sv
// DMI-to-Wishbone bridge: accepts one DMI request at a time, runs a single Wishbone
// classic cycle, waits for the slave to release ack, then presents the response.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : wishbone_dmi_master_if.master (DMI cmd/rsp handshakes + Wishbone master)
// Parameters:
//   TIMEOUT_CYCLES : max cycles waited for ack to rise, and again for it to fall
//   CNT_W          : timeout counter width, TIMEOUT_CYCLES < 2**CNT_W
module wishbone_dmi_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  wishbone_dmi_master_if.master         bus
);

  typedef enum logic [1:0] {StIdle, StReq, StRelease, StResp} state_e;

  // Counter value on the last allowed wait cycle.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  // Keeps cmd_ready_o low while reset is held and until the first edge after release.
  logic              init_q, init_d;

  logic accept;
  logic cnt_last;

  assign accept   = (state_q == StIdle) && init_q && bus.cmd_valid_i;
  assign cnt_last = (cnt_q == CntLast);
  assign init_d   = 1'b1;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack has priority over the timeout on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StReq;
      StReq:     if (bus.ack_i || cnt_last) state_d = StRelease;
      StRelease: if (!bus.ack_i || cnt_last) state_d = StResp;
      StResp:    if (bus.rsp_ready_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = bus.cmd_addr_i;
          we_d    = bus.cmd_we_i;
          wdata_d = bus.cmd_wdata_i;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (bus.ack_i) begin
          // Captured for writes too: the slave returns the written value.
          rdata_d = bus.data_i;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_last) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRelease: begin
        if (bus.ack_i) begin
          if (cnt_last) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StResp: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      init_q  <= init_d;
    end
  end

  // Outputs decoded from state so reset drops cyc/stb without waiting for an edge.
  always_comb begin
    bus.cmd_ready_o = (state_q == StIdle) && init_q;
    bus.cyc_o       = (state_q == StReq);
    bus.stb_o       = (state_q == StReq);
    bus.rsp_valid_o = (state_q == StResp);
    bus.addr_o      = addr_q;
    bus.we_o        = we_q;
    bus.data_o      = wdata_q;
    bus.rsp_rdata_o = rdata_q;
    bus.rsp_err_o   = err_q;
  end

endmodule

// File: tb/tb_wishbone_dmi_master.sv
// Self-checking bench for wishbone_dmi_master: directed vector table, reset and
// backpressure sequences, then randomized requests checked against a register-map model.
module tb_wishbone_dmi_master;

  localparam int unsigned T = 8;
  localparam int ModeNormal = 0;  // ack one cycle after stb, held until stb drops
  localparam int ModeNever  = 1;  // slave never answers
  localparam int ModeStuck  = 2;  // ack never falls

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  wishbone_dmi_master_if bus ();

  wishbone_dmi_master #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (8)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- Wishbone slave: data0, data1, dmcontrol ----------------
  int          slave_mode = ModeNormal;
  logic        ack_q      = 1'b0;
  logic [63:0] sdata_q    = '0;
  logic [63:0] smem [3]   = '{default: 64'h0};

  assign bus.ack_i  = ack_q;
  assign bus.data_i = sdata_q;

  always @(posedge clk_i) begin
    if (slave_mode == ModeNever) begin
      ack_q <= 1'b0;
    end else begin
      if (bus.cyc_o && bus.stb_o && !ack_q) begin
        case (bus.addr_o)
          32'h04: begin
            if (bus.we_o) smem[0] <= bus.data_o;
            sdata_q <= bus.we_o ? bus.data_o : smem[0];
          end
          32'h05: begin
            if (bus.we_o) smem[1] <= bus.data_o;
            sdata_q <= bus.we_o ? bus.data_o : smem[1];
          end
          32'h10: begin
            if (bus.we_o) smem[2] <= bus.data_o;
            sdata_q <= bus.we_o ? bus.data_o : smem[2];
          end
          default: sdata_q <= '0;
        endcase
      end
      ack_q <= (bus.cyc_o && bus.stb_o) || (slave_mode == ModeStuck && ack_q);
    end
  end

  // ---------------- Reference model ----------------
  logic [63:0] mreg [3] = '{default: 64'h0};

  // Expected outcome of one transaction from the bridge rules:
  //  normal: slave answers, 1 cycle stb->ack, 1 cycle to capture, 2 cycles release -> 4
  //  never : stb held T cycles, then ack already low -> T+1, rdata 0, err
  //  stuck : captured at cycle 2, then T cycles of held ack -> T+2, data kept, err
  task automatic model_exp(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                           input int mode, output logic [63:0] rdata, output logic err,
                           output int lat, output int cyc);
    int idx;
    idx = (addr == 32'h04) ? 0 : (addr == 32'h05) ? 1 : (addr == 32'h10) ? 2 : -1;
    if (mode == ModeNever) begin
      rdata = '0;
      err   = 1'b1;
      lat   = T + 1;
      cyc   = T;
    end else begin
      if (idx >= 0 && we) mreg[idx] = wdata;
      rdata = (idx >= 0) ? mreg[idx] : 64'h0;
      err   = (mode == ModeStuck);
      lat   = (mode == ModeStuck) ? T + 2 : 4;
      cyc   = 2;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- One DMI transaction ----------------
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                        input int mode, input int bp, output logic [63:0] rdata,
                        output logic err, output int lat, output int cyc_cnt,
                        output logic proto_ok, output logic stall_ok);
    int n;
    proto_ok = 1'b1;
    stall_ok = 1'b1;
    cyc_cnt  = 0;
    lat      = 0;
    rdata    = '0;
    err      = 1'b0;
    @(negedge clk_i);
    slave_mode      = mode;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    n = 0;
    while (!bus.cmd_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.cmd_ready_o) begin
      check("accept_wait", {63'h0, bus.cmd_ready_o}, 64'h1);
      bus.cmd_valid_i = 1'b0;
      return;
    end
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
    // Scramble the request so held bus values must come from the bridge's registers.
    bus.cmd_we_i    = ~we;
    bus.cmd_addr_i  = ~addr;
    bus.cmd_wdata_i = ~wdata;
    while (!bus.rsp_valid_o && lat < 50) begin
      if (bus.cyc_o) cyc_cnt++;
      if (bus.cyc_o !== bus.stb_o || bus.cmd_ready_o) proto_ok = 1'b0;
      if (bus.cyc_o && (bus.addr_o !== addr || bus.data_o !== wdata || bus.we_o !== we))
        proto_ok = 1'b0;
      @(negedge clk_i);
      lat++;
    end
    if (!bus.rsp_valid_o) begin
      check("rsp_wait", {63'h0, bus.rsp_valid_o}, 64'h1);
      return;
    end
    rdata = bus.rsp_rdata_o;
    err   = bus.rsp_err_o;
    repeat (bp) begin
      @(negedge clk_i);
      if (!bus.rsp_valid_o || bus.rsp_rdata_o !== rdata || bus.rsp_err_o !== err ||
          bus.cmd_ready_o || bus.cyc_o)
        stall_ok = 1'b0;
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
    // Back in idle right after the handshake, ready for a new request.
    if (bus.rsp_valid_o || !bus.cmd_ready_o) proto_ok = 1'b0;
    slave_mode = ModeNormal;
    @(negedge clk_i);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          mode;
    int          bp;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic run_and_check(input string tag, input logic we, input logic [31:0] addr,
                               input logic [63:0] wdata, input int mode, input int bp,
                               input logic [63:0] e_rdata, input logic e_err,
                               input int e_lat, input int e_cyc);
    logic [63:0] rdata;
    logic        err, proto_ok, stall_ok;
    int          lat, cyc;
    do_txn(we, addr, wdata, mode, bp, rdata, err, lat, cyc, proto_ok, stall_ok);
    check({tag, "_rdata"}, rdata, e_rdata);
    check({tag, "_err"}, {63'h0, err}, {63'h0, e_err});
    check({tag, "_latency"}, 64'(lat), 64'(e_lat));
    check({tag, "_cyc_cycles"}, 64'(cyc), 64'(e_cyc));
    check({tag, "_protocol"}, {63'h0, proto_ok}, 64'h1);
    if (bp > 0) check({tag, "_backpressure"}, {63'h0, stall_ok}, 64'h1);
  endtask

  initial begin
    logic [63:0] m_rdata;
    logic        m_err;
    int          m_lat, m_cyc;

    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;

    vecs[0] = '{1'b1, 32'h10, 64'h8000_0000, ModeNormal, 0, 64'h8000_0000, 1'b0, 4, 2};
    vecs[1] = '{1'b1, 32'h04, 64'hDEAD_BEEF_1234_5678, ModeNormal, 0,
                64'hDEAD_BEEF_1234_5678, 1'b0, 4, 2};
    vecs[2] = '{1'b0, 32'h04, 64'h0, ModeNormal, 0, 64'hDEAD_BEEF_1234_5678, 1'b0, 4, 2};
    vecs[3] = '{1'b0, 32'h20, 64'h0, ModeNormal, 0, 64'h0, 1'b0, 4, 2};
    vecs[4] = '{1'b0, 32'h05, 64'h0, ModeNever, 0, 64'h0, 1'b1, T + 1, T};
    vecs[5] = '{1'b0, 32'h04, 64'h0, ModeStuck, 0, 64'hDEAD_BEEF_1234_5678, 1'b1, T + 2, 2};
    vecs[6] = '{1'b0, 32'h10, 64'h0, ModeNormal, 10, 64'h8000_0000, 1'b0, 4, 2};

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_cmd_ready", {63'h0, bus.cmd_ready_o}, 64'h0);
    check("rst_cyc", {63'h0, bus.cyc_o}, 64'h0);
    check("rst_stb", {63'h0, bus.stb_o}, 64'h0);
    check("rst_we", {63'h0, bus.we_o}, 64'h0);
    check("rst_rsp_valid", {63'h0, bus.rsp_valid_o}, 64'h0);
    check("rst_rsp_err", {63'h0, bus.rsp_err_o}, 64'h0);
    check("rst_addr", {32'h0, bus.addr_o}, 64'h0);
    check("rst_data", bus.data_o, 64'h0);
    check("rst_rdata", bus.rsp_rdata_o, 64'h0);
    rst_i = 1'b1;
    #1 check("rel_cmd_ready_before_edge", {63'h0, bus.cmd_ready_o}, 64'h0);
    @(negedge clk_i);
    check("rel_cmd_ready_after_edge", {63'h0, bus.cmd_ready_o}, 64'h1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      model_exp(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mode,
                m_rdata, m_err, m_lat, m_cyc);
      run_and_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].mode, vecs[i].bp, vecs[i].exp_rdata, vecs[i].exp_err,
                    vecs[i].exp_lat, vecs[i].exp_cyc);
    end
    check("slave_dmcontrol", smem[2], 64'h8000_0000);

    // Reset while the bus cycle is open: cyc drops at once, no response survives.
    @(negedge clk_i);
    slave_mode      = ModeNever;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b1;
    bus.cmd_addr_i  = 32'h05;
    bus.cmd_wdata_i = 64'h1111_2222_3333_4444;
    @(negedge clk_i);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk_i);
    check("midrst_cyc_before", {63'h0, bus.cyc_o}, 64'h1);
    #2 rst_i = 1'b0;
    #1 check("midrst_cyc", {63'h0, bus.cyc_o}, 64'h0);
    check("midrst_stb", {63'h0, bus.stb_o}, 64'h0);
    check("midrst_rsp_valid", {63'h0, bus.rsp_valid_o}, 64'h0);
    @(negedge clk_i);
    rst_i      = 1'b1;
    slave_mode = ModeNormal;
    repeat (3) @(negedge clk_i);
    check("midrst_no_rsp", {63'h0, bus.rsp_valid_o}, 64'h0);
    model_exp(1'b0, 32'h05, 64'h0, ModeNormal, m_rdata, m_err, m_lat, m_cyc);
    run_and_check("after_rst", 1'b0, 32'h05, 64'h0, ModeNormal, 0, m_rdata, m_err,
                  m_lat, m_cyc);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic        r_we;
      logic [31:0] r_addr;
      logic [63:0] r_wdata;
      int          r_mode, sel;
      r_we    = 1'($urandom_range(0, 1));
      sel     = $urandom_range(0, 3);
      r_addr  = (sel == 0) ? 32'h04 : (sel == 1) ? 32'h05 : (sel == 2) ? 32'h10 :
                32'h100 + 32'($urandom_range(0, 255));
      r_wdata = {$urandom, $urandom};
      sel     = $urandom_range(0, 9);
      r_mode  = (sel == 8) ? ModeNever : (sel == 9) ? ModeStuck : ModeNormal;
      model_exp(r_we, r_addr, r_wdata, r_mode, m_rdata, m_err, m_lat, m_cyc);
      run_and_check($sformatf("rnd%0d", i), r_we, r_addr, r_wdata, r_mode,
                    $urandom_range(0, 3), m_rdata, m_err, m_lat, m_cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wishbone_dmi_master.md
WISHBONE_DMI_MASTER -- requirements
Module: wishbone_dmi_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles waited for ack_i to rise, and separately for it to fall.
REQ-002 SHALL have parameter CNT_W, default 8: width of the timeout counter; TIMEOUT_CYCLES < 2^CNT_W.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid_i, input, 1: upstream DMI request valid.
REQ-006 SHALL have port cmd_ready_o, output, 1: request accepted when high with cmd_valid_i.
REQ-007 SHALL have port cmd_we_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr_i, input, 32: DM register address (0x04 data0, 0x05 data1, 0x10 dmcontrol).
REQ-009 SHALL have port cmd_wdata_i, input, 64: write data.
REQ-010 SHALL have port rsp_valid_o, output, 1: response available.
REQ-011 SHALL have port rsp_ready_i, input, 1: upstream consumes response.
REQ-012 SHALL have port rsp_rdata_o, output, 64: data captured from slave.
REQ-013 SHALL have port rsp_err_o, output, 1: 1 = timeout occurred.
REQ-014 SHALL have Wishbone master ports: addr_o out 32, we_o out 1, data_o out 64, cyc_o out 1, stb_o out 1, data_i in 64, ack_i in 1.

Function
REQ-015 SHALL implement states IDLE, REQ, RELEASE, RESP.
REQ-016 IDLE: cmd_ready_o=1; on cmd_valid_i=1 register addr/we/wdata into addr_o/we_o/data_o, clear counter, go REQ.
REQ-017 REQ: cyc_o=stb_o=1, first asserted in the cycle after acceptance; addr_o/we_o/data_o held stable for the whole state.
REQ-018 REQ: on an edge where ack_i=1, capture data_i into rsp_rdata_o for reads and writes (write readback), clear rsp_err_o, go RELEASE.
REQ-019 REQ: counter increments each cycle without ack; when it equals TIMEOUT_CYCLES, set rsp_err_o=1 and rsp_rdata_o=0, go RELEASE.
REQ-020 RELEASE: cyc_o=stb_o=0; counter cleared on entry; go RESP on the first edge with ack_i=0 (slave holds ack until strobe drops).
REQ-021 RELEASE: if ack_i remains 1 for TIMEOUT_CYCLES cycles, set rsp_err_o=1, go RESP; rsp_rdata_o keeps its captured value.
REQ-022 RESP: rsp_valid_o=1; rsp_rdata_o/rsp_err_o stable; on rsp_ready_i=1 go IDLE.
REQ-023 cmd_ready_o SHALL be 0 in REQ, RELEASE and RESP; at most one transaction outstanding.
REQ-024 A new request SHALL be acceptable no earlier than the cycle after the response handshake (no IDLE bypass).
REQ-025 Minimum latency, acceptance to rsp_valid_o, with an ack-on-first-cycle slave: 4 cycles.
REQ-026 Simultaneous events: in REQ, ack_i on the timeout cycle SHALL count as success (ack wins).
REQ-027 cyc_o and stb_o SHALL always be equal; no retry and no burst.
REQ-028 ack_i SHALL be ignored in IDLE and RESP.

Reset
REQ-029 While rst_i=0: state IDLE; cyc_o, stb_o, we_o, rsp_valid_o and rsp_err_o are 0; addr_o, data_o and rsp_rdata_o are 0; cmd_ready_o=0 while reset is asserted, then 1 from the first edge after release.
REQ-030 Reset mid-transaction SHALL drop cyc_o/stb_o immediately (asynchronously) and discard the pending response.

Verification
REQ-031 Write: cmd we=1 addr=0x10 wdata=0x80000000 -> one cyc/stb pulse with addr_o=0x10, data_o=0x80000000; rsp_valid_o with err=0; slave dmcontrol = 0x80000000.
REQ-032 Read-back: write 0x04 with 0xDEADBEEF12345678, then read 0x04 -> rsp_rdata_o=0xDEADBEEF12345678, err=0.
REQ-033 Unmapped read: addr 0x20 -> rsp_rdata_o=0, err=0.
REQ-034 Timeout: ack_i tied 0, TIMEOUT_CYCLES=8 -> cyc_o drops after 8 cycles; rsp_err_o=1, rdata=0; stuck ack_i=1 in RELEASE also gives err=1.
REQ-035 Backpressure/reset: hold rsp_ready_i=0 for 10 cycles -> response stable and cmd_ready_o=0; rst_i=0 pulse in REQ -> cyc_o=0 at once, next command completes normally.
